serial_sub_unit: RTL and testbench

//  Bit-serial unsigned subtractor: diff = a - b, computed LSB-first, one bit per clock.

---
 rtl/serial_sub_unit_pkg.sv | 10 +
 rtl/serial_sub_unit_if.sv | 26 ++
 rtl/serial_sub_unit_mux_diff_slice.sv | 29 ++
 rtl/serial_sub_unit.sv | 109 ++++++++++
 tb/tb_serial_sub_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_unit_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

endpackage

// File: rtl/serial_sub_unit_if.sv
// Operand/result handshake bundle between producer, subtractor and consumer.
interface serial_sub_unit_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow_out, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow_out, busy
  );

endinterface

// File: rtl/serial_sub_unit_mux_diff_slice.sv
// One-bit difference slice built only from 2:1 muxes, the subtract-side twin
// of the mux sum slice.
module mux2to1_slice (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

module mux_diff_slice (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic x;

  // x = a^b; when a!=b the borrow out is b itself, otherwise it propagates bin
  mux2to1_slice u_xor  (.sel(a), .d0(b),   .d1(~b),   .y(x));
  mux2to1_slice u_diff (.sel(x), .d0(bin), .d1(~bin), .y(d));
  mux2to1_slice u_bor  (.sel(x), .d0(bin), .d1(b),    .y(bout));

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module serial_sub_unit
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_unit_if.slave  bus
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bor_q, bor_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             slice_d;
  logic             slice_bout;
  logic [WIDTH-1:0] res_next;

  mux_diff_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bor_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // The final bit goes straight into diff, so the partial result only needs WIDTH-1 bits.
  assign res_next = {slice_d, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bor_d   = bor_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_next[WIDTH-1:1];
        bor_d = slice_bout;
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_next;
          bout_d  = slice_bout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bor_q   <= bor_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.in_ready   = (state_q == IDLE);
    bus.out_valid  = (state_q == DONE);
    bus.busy       = (state_q != IDLE);
    bus.diff       = diff_q;
    bus.borrow_out = bout_q;
  end

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed and randomised checks of serial_sub_unit at WIDTH=8 and WIDTH=13.
module tb_serial_sub_unit;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  serial_sub_unit_if #(.WIDTH(8))  bus8  ();
  serial_sub_unit_if #(.WIDTH(13)) bus13 ();

  serial_sub_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_sub_unit #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst), .bus(bus13));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdy(input bit s);
    return s ? 32'(bus13.in_ready) : 32'(bus8.in_ready);
  endfunction
  function automatic logic [31:0] vld(input bit s);
    return s ? 32'(bus13.out_valid) : 32'(bus8.out_valid);
  endfunction
  function automatic logic [31:0] bsy(input bit s);
    return s ? 32'(bus13.busy) : 32'(bus8.busy);
  endfunction
  function automatic logic [31:0] bor(input bit s);
    return s ? 32'(bus13.borrow_out) : 32'(bus8.borrow_out);
  endfunction
  function automatic logic [31:0] dif(input bit s);
    return s ? 32'(bus13.diff) : 32'(bus8.diff);
  endfunction

  task automatic drive_in(input bit s, input logic v, input logic [12:0] a, input logic [12:0] b);
    if (s) begin
      bus13.in_valid = v; bus13.a = a; bus13.b = b;
    end else begin
      bus8.in_valid = v; bus8.a = a[7:0]; bus8.b = b[7:0];
    end
  endtask

  task automatic drive_ordy(input bit s, input logic v);
    if (s) bus13.out_ready = v;
    else   bus8.out_ready  = v;
  endtask

  // Runs from just after the accepting edge to the completed result handshake.
  task automatic collect(input bit s, input logic [12:0] exp_d, input logic exp_b,
                         input int unsigned post, input string tag);
    int unsigned lat = 0;
    int unsigned w = s ? 13 : 8;
    chk({tag, "_busy"}, bsy(s), 1);
    do begin
      tick;
      lat++;
    end while (vld(s) !== 32'd1 && lat < 40);
    chk({tag, "_lat"}, lat, w);
    chk({tag, "_diff"}, dif(s), 32'(exp_d));
    chk({tag, "_bor"}, bor(s), 32'(exp_b));
    for (int unsigned i = 0; i < post; i++) begin
      tick;
      chk({tag, "_hold_v"}, vld(s), 1);
      chk({tag, "_hold_d"}, dif(s), 32'(exp_d));
    end
    drive_ordy(s, 1'b1);
    tick;
    drive_ordy(s, 1'b0);
    chk({tag, "_idle"}, vld(s), 0);
  endtask

  task automatic do_op(input bit s, input logic [12:0] a, input logic [12:0] b,
                       input logic [12:0] exp_d, input logic exp_b,
                       input int unsigned pre, input int unsigned post, input string tag);
    int unsigned n = 0;
    repeat (pre) tick;
    while (rdy(s) !== 32'd1 && n < 100) begin
      tick;
      n++;
    end
    chk({tag, "_rdy"}, rdy(s), 1);
    drive_in(s, 1'b1, a, b);
    tick;
    drive_in(s, 1'b0, 13'($urandom), 13'($urandom));
    collect(s, exp_d, exp_b, post, tag);
  endtask

  initial begin
    int unsigned n;
    logic        seen;
    logic [12:0] ra, rb, mask;
    logic [13:0] r;

    rst = 1'b1;
    drive_in(0, 1'b0, '0, '0);
    drive_in(1, 1'b0, '0, '0);
    drive_ordy(0, 1'b0);
    drive_ordy(1, 1'b0);
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", rdy(0), 1);
    chk("rst_out_valid", vld(0), 0);
    chk("rst_busy", bsy(0), 0);
    chk("rst_diff", dif(0), 0);
    chk("rst_bor", bor(0), 0);
    chk("rst13_in_ready", rdy(1), 1);
    chk("rst13_out_valid", vld(1), 0);

    do_op(0, 'h5A, 'h23, 'h37, 1'b0, 0, 0, "t2");
    do_op(0, 'h10, 'h20, 'hF0, 1'b1, 0, 0, "t3a");
    do_op(0, 'h00, 'hFF, 'h01, 1'b1, 0, 0, "t3b");
    do_op(0, 'hA5, 'hA5, 'h00, 1'b0, 0, 0, "t3c");
    do_op(0, 'hFF, 'h00, 'hFF, 1'b0, 1, 2, "t3d");

    // backpressure: new operands presented throughout SHIFT/DONE must wait
    drive_in(0, 1'b1, 'h33, 'h11);
    tick;
    drive_in(0, 1'b1, 'hC3, 'h3C);
    n = 0;
    while (vld(0) !== 32'd1 && n < 40) begin
      tick;
      n++;
    end
    chk("t4_lat", n, 8);
    for (int unsigned i = 0; i < 5; i++) begin
      chk("t4_diff", dif(0), 'h22);
      chk("t4_bor", bor(0), 0);
      chk("t4_in_ready", rdy(0), 0);
      chk("t4_out_valid", vld(0), 1);
      tick;
    end
    drive_ordy(0, 1'b1);
    tick;
    drive_ordy(0, 1'b0);
    chk("t4_idle_rdy", rdy(0), 1);
    chk("t4_idle_v", vld(0), 0);
    tick;
    drive_in(0, 1'b0, '0, '0);
    collect(0, 'h87, 1'b0, 0, "t4b");

    // reset while cnt==3 discards the operation
    drive_in(0, 1'b1, 'h44, 'h11);
    tick;
    drive_in(0, 1'b0, '0, '0);
    tick;
    tick;
    tick;
    chk("t5_busy_pre", bsy(0), 1);
    rst = 1'b1;
    tick;
    chk("t5_in_ready", rdy(0), 1);
    chk("t5_out_valid", vld(0), 0);
    chk("t5_busy", bsy(0), 0);
    chk("t5_diff", dif(0), 0);
    chk("t5_bor", bor(0), 0);
    tick;
    rst = 1'b0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      tick;
      if (vld(0) !== 32'd0) seen = 1'b1;
    end
    chk("t5_no_valid", 32'(seen), 0);
    do_op(0, 'h80, 'h01, 'h7F, 1'b0, 0, 0, "t5b");

    for (int unsigned k = 0; k < 1000; k++) begin
      bit s;
      s    = (k >= 500);
      mask = s ? 13'h1FFF : 13'h00FF;
      ra   = 13'($urandom) & mask;
      rb   = (k % 17 == 0) ? ra : (13'($urandom) & mask);
      r    = {1'b0, ra} - {1'b0, rb};
      do_op(s, ra, rb, r[12:0] & mask, r[13], $urandom_range(0, 2), $urandom_range(0, 3),
            s ? "rnd13" : "rnd8");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
